// File: rtl/alu_exec_stage.sv
// ============================================================================
// Module   : alu_exec_stage
// Purpose  : Execute stage with single-cycle ALU ops, registered result and
//            Z/N/C/V flags, write-back into the A/B registers, and an optional
//            WIDTH-step shift-add multiply enabled by the ALU_MUL_EN macro.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_exec_stage #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic [3:0]       alu_op,
    input  logic             start,
    input  logic             load_a,
    input  logic             load_b,
    output logic [WIDTH-1:0] alu_out,
    output logic [WIDTH-1:0] reg_a,
    output logic [WIDTH-1:0] reg_b,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_c,
    output logic             flag_v,
    output logic             busy,
    output logic             done
);
    localparam logic [3:0] C_OP_ADD  = 4'd0;
    localparam logic [3:0] C_OP_SUB  = 4'd1;
    localparam logic [3:0] C_OP_AND  = 4'd2;
    localparam logic [3:0] C_OP_OR   = 4'd3;
    localparam logic [3:0] C_OP_XOR  = 4'd4;
    localparam logic [3:0] C_OP_NOT  = 4'd5;
    localparam logic [3:0] C_OP_SHL  = 4'd6;
    localparam logic [3:0] C_OP_SHR  = 4'd7;
    localparam logic [3:0] C_OP_PASS = 4'd8;
    localparam int         C_MSB     = WIDTH - 1;

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH-1:0] w_sc_res;
    logic             w_sc_c;
    logic             w_sc_v;
    logic             w_sc_valid;
    logic             w_busy;
    logic             w_accept;
    logic             w_mul_start;
    logic             w_mul_last;
    logic [WIDTH-1:0] w_mul_res;
    logic             w_mul_c;
    logic             w_mul_ld_a;
    logic             w_mul_ld_b;

    logic [WIDTH-1:0] r_alu_out_q, w_alu_out_d;
    logic [WIDTH-1:0] r_reg_a_q,   w_reg_a_d;
    logic [WIDTH-1:0] r_reg_b_q,   w_reg_b_d;
    logic             r_flag_z_q,  w_flag_z_d;
    logic             r_flag_n_q,  w_flag_n_d;
    logic             r_flag_c_q,  w_flag_c_d;
    logic             r_flag_v_q,  w_flag_v_d;
    logic             r_done_q,    w_done_d;

    logic             w_commit;
    logic [WIDTH-1:0] w_res;
    logic             w_c;
    logic             w_v;
    logic             w_wr_a;
    logic             w_wr_b;

    assign w_sum  = {1'b0, a_in} + {1'b0, b_in};
    assign w_diff = {1'b0, a_in} - {1'b0, b_in};

    // Single-cycle ALU; ops outside 0..8 report invalid and leave state alone
    always_comb begin
        w_sc_res   = '0;
        w_sc_c     = 1'b0;
        w_sc_v     = 1'b0;
        w_sc_valid = 1'b1;
        case (alu_op)
            C_OP_ADD: begin
                w_sc_res = w_sum[WIDTH-1:0];
                w_sc_c   = w_sum[WIDTH];
                w_sc_v   = (a_in[C_MSB] == b_in[C_MSB]) && (w_sum[C_MSB] != a_in[C_MSB]);
            end
            C_OP_SUB: begin
                w_sc_res = w_diff[WIDTH-1:0];
                w_sc_c   = w_diff[WIDTH];
                w_sc_v   = (a_in[C_MSB] != b_in[C_MSB]) && (w_diff[C_MSB] != a_in[C_MSB]);
            end
            C_OP_AND:  w_sc_res = a_in & b_in;
            C_OP_OR:   w_sc_res = a_in | b_in;
            C_OP_XOR:  w_sc_res = a_in ^ b_in;
            C_OP_NOT:  w_sc_res = ~a_in;
            C_OP_SHL: begin
                w_sc_res = {a_in[WIDTH-2:0], 1'b0};
                w_sc_c   = a_in[C_MSB];
            end
            C_OP_SHR: begin
                w_sc_res = {1'b0, a_in[WIDTH-1:1]};
                w_sc_c   = a_in[0];
            end
            C_OP_PASS: w_sc_res = b_in;
            default:   w_sc_valid = 1'b0;
        endcase
    end

    assign w_accept = start & ~w_busy;

`ifdef ALU_MUL_EN
    localparam logic [3:0] C_OP_MUL = 4'd9;
    localparam logic       C_S_IDLE = 1'b0;
    localparam logic       C_S_MUL  = 1'b1;
    localparam int         C_CW     = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    logic                 r_state_q,  w_state_d;
    logic [C_CW-1:0]      r_cnt_q,    w_cnt_d;
    logic [2*WIDTH-1:0]   r_acc_q,    w_acc_d;
    logic [2*WIDTH-1:0]   r_mcand_q,  w_mcand_d;
    logic [WIDTH-1:0]     r_mplier_q, w_mplier_d;
    logic                 r_ld_a_q,   w_ld_a_d;
    logic                 r_ld_b_q,   w_ld_b_d;
    logic [2*WIDTH-1:0]   w_acc_step;

    assign w_mul_start = w_accept && (alu_op == C_OP_MUL);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= C_S_IDLE;
        end else begin
            r_state_q <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = r_state_q;
        case (r_state_q)
            C_S_IDLE: if (w_mul_start) w_state_d = C_S_MUL;
            C_S_MUL:  if (w_mul_last)  w_state_d = C_S_IDLE;
            default:  w_state_d = C_S_IDLE;
        endcase
    end

    always_comb begin
        w_busy     = (r_state_q == C_S_MUL);
        w_mul_last = w_busy && (r_cnt_q == C_CW'(WIDTH - 1));
    end

    // One shift-add step per cycle: multiplicand walks left, multiplier right
    assign w_acc_step = r_acc_q + (r_mplier_q[0] ? r_mcand_q : '0);
    assign w_mul_res  = w_acc_step[WIDTH-1:0];
    assign w_mul_c    = |w_acc_step[2*WIDTH-1:WIDTH];
    assign w_mul_ld_a = r_ld_a_q;
    assign w_mul_ld_b = r_ld_b_q;

    always_comb begin
        w_cnt_d    = r_cnt_q;
        w_acc_d    = r_acc_q;
        w_mcand_d  = r_mcand_q;
        w_mplier_d = r_mplier_q;
        w_ld_a_d   = r_ld_a_q;
        w_ld_b_d   = r_ld_b_q;
        if (w_mul_start) begin
            w_cnt_d    = '0;
            w_acc_d    = '0;
            w_mcand_d  = {{WIDTH{1'b0}}, a_in};
            w_mplier_d = b_in;
            w_ld_a_d   = load_a;
            w_ld_b_d   = load_b;
        end else if (w_busy) begin
            w_acc_d    = w_acc_step;
            w_mcand_d  = r_mcand_q << 1;
            w_mplier_d = r_mplier_q >> 1;
            w_cnt_d    = w_mul_last ? '0 : r_cnt_q + C_CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt_q    <= '0;
            r_acc_q    <= '0;
            r_mcand_q  <= '0;
            r_mplier_q <= '0;
            r_ld_a_q   <= 1'b0;
            r_ld_b_q   <= 1'b0;
        end else begin
            r_cnt_q    <= w_cnt_d;
            r_acc_q    <= w_acc_d;
            r_mcand_q  <= w_mcand_d;
            r_mplier_q <= w_mplier_d;
            r_ld_a_q   <= w_ld_a_d;
            r_ld_b_q   <= w_ld_b_d;
        end
    end
`else
    assign w_busy      = 1'b0;
    assign w_mul_start = 1'b0;
    assign w_mul_last  = 1'b0;
    assign w_mul_res   = '0;
    assign w_mul_c     = 1'b0;
    assign w_mul_ld_a  = 1'b0;
    assign w_mul_ld_b  = 1'b0;
`endif

    // Commit: multiply completion, or an accepted single-cycle op / NOP
    always_comb begin
        w_alu_out_d = r_alu_out_q;
        w_reg_a_d   = r_reg_a_q;
        w_reg_b_d   = r_reg_b_q;
        w_flag_z_d  = r_flag_z_q;
        w_flag_n_d  = r_flag_n_q;
        w_flag_c_d  = r_flag_c_q;
        w_flag_v_d  = r_flag_v_q;
        w_done_d    = 1'b0;
        w_commit    = 1'b0;
        w_res       = w_sc_res;
        w_c         = w_sc_c;
        w_v         = w_sc_v;
        w_wr_a      = load_a;
        w_wr_b      = load_b;
        if (w_mul_last) begin
            w_commit = 1'b1;
            w_done_d = 1'b1;
            w_res    = w_mul_res;
            w_c      = w_mul_c;
            w_v      = 1'b0;
            w_wr_a   = w_mul_ld_a;
            w_wr_b   = w_mul_ld_b;
        end else if (w_accept && !w_mul_start) begin
            w_done_d = 1'b1;
            w_commit = w_sc_valid;
        end
        if (w_commit) begin
            w_alu_out_d = w_res;
            w_flag_z_d  = (w_res == '0);
            w_flag_n_d  = w_res[C_MSB];
            w_flag_c_d  = w_c;
            w_flag_v_d  = w_v;
            if (w_wr_a) w_reg_a_d = w_res;
            if (w_wr_b) w_reg_b_d = w_res;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_alu_out_q <= '0;
            r_reg_a_q   <= '0;
            r_reg_b_q   <= '0;
            r_flag_z_q  <= 1'b0;
            r_flag_n_q  <= 1'b0;
            r_flag_c_q  <= 1'b0;
            r_flag_v_q  <= 1'b0;
            r_done_q    <= 1'b0;
        end else begin
            r_alu_out_q <= w_alu_out_d;
            r_reg_a_q   <= w_reg_a_d;
            r_reg_b_q   <= w_reg_b_d;
            r_flag_z_q  <= w_flag_z_d;
            r_flag_n_q  <= w_flag_n_d;
            r_flag_c_q  <= w_flag_c_d;
            r_flag_v_q  <= w_flag_v_d;
            r_done_q    <= w_done_d;
        end
    end

    assign alu_out = r_alu_out_q;
    assign reg_a   = r_reg_a_q;
    assign reg_b   = r_reg_b_q;
    assign flag_z  = r_flag_z_q;
    assign flag_n  = r_flag_n_q;
    assign flag_c  = r_flag_c_q;
    assign flag_v  = r_flag_v_q;
    assign busy    = w_busy;
    assign done    = r_done_q;

endmodule

`default_nettype wire
